// File: rtl/unmask_hpc2.sv
// Serial share recombiner: XORs the NS shares of one masked word, one share per cycle.
// Optional build macro UNMASK_HPC2_ZEROIZE_EN clears share/result registers once they are no longer needed.
module unmask_hpc2 #(
  parameter int W  = 8,
  parameter int NS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NS*W-1:0] in_data,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW = ($clog2(NS) < 1) ? 1 : $clog2(NS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t              state_reg;
  logic [NS*W-1:0]     sr_reg;
  logic [W-1:0]        acc_reg;
  logic                lr_reg;
  logic [CW-1:0]       cnt_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [W-1:0]        share_arr [NS];

  // Share j of the captured word, selected by the counter one per cycle.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_share
      assign share_arr[gi] = sr_reg[gi*W +: W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      sr_reg        <= '0;
      lr_reg        <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sr_reg       <= in_data;
            acc_reg      <= in_data[W-1:0];
            lr_reg       <= in_last;
            cnt_reg      <= CW'(1);
            state_reg    <= ACCUM;
            in_ready_reg <= 1'b0;
          end
        end
        ACCUM: begin
          acc_reg <= acc_reg ^ share_arr[cnt_reg];
          // Counter saturates at NS-1 so it never indexes past the last share.
          if (cnt_reg == LAST_CNT) begin
            state_reg     <= OUT;
            out_valid_reg <= 1'b1;
`ifdef UNMASK_HPC2_ZEROIZE_EN
            sr_reg        <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
`ifdef UNMASK_HPC2_ZEROIZE_EN
            acc_reg       <= '0;
            lr_reg        <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = acc_reg;
  assign out_last  = lr_reg;

endmodule

// File: tb/tb_unmask_hpc2.sv
// Randomised and directed checks of unmask_hpc2 against an XOR-reduction reference model.
module tb_unmask_hpc2;
  localparam int W  = 8;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*W-1:0] in_data;
  logic            in_last, in_valid, in_ready;
  logic [W-1:0]    out_data;
  logic            out_last, out_valid, out_ready;

  logic [2*W-1:0]  in_data2;
  logic            in_valid2, in_ready2, out_valid2, out_last2;
  logic [W-1:0]    out_data2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NS*W-1:0] words[$];
  logic            lasts[$];

  always #5 clk = ~clk;

  unmask_hpc2 #(.W(W), .NS(NS)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  unmask_hpc2 #(.W(W), .NS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_data(in_data2), .in_last(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_last(out_last2), .out_valid(out_valid2), .out_ready(1'b1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_xor(input logic [NS*W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < NS; j++) r = r ^ v[j*W +: W];
    return r;
  endfunction

  // One word with a given number of back-pressure cycles in the output state.
  task automatic one_word(input logic [NS*W-1:0] d, input logic l, input int bp);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    in_data = d; in_last = l; in_valid = 1'b1; out_ready = 1'b0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = (NS*W)'($urandom);
    in_last  = ~l;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(NS));
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(ref_xor(d)));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("out_data", 32'(out_data), 32'(ref_xor(d)));
    check("out_last", 32'(out_last), 32'(l));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
`ifdef UNMASK_HPC2_ZEROIZE_EN
    check("zeroized_data", 32'(out_data), 32'd0);
    check("zeroized_last", 32'(out_last), 32'd0);
`else
    check("retained_data", 32'(out_data), 32'(ref_xor(d)));
    check("retained_last", 32'(out_last), 32'(l));
`endif
    $display("word %h last=%0d bp=%0d -> %h", d, l, bp, out_data);
  endtask

  // Streams the words queue; in_valid stays high while words remain.
  task automatic stream(input bit rand_ready, input int gap);
    logic [W-1:0] exp_q[$];
    logic         exp_l[$];
    logic [W-1:0] hold_data;
    int  idx, cyc, acc_cyc, budget;
    bit  lat_pending, hold;
    idx = 0; cyc = 0; acc_cyc = -1; budget = 0; lat_pending = 0; hold = 0; hold_data = '0;
    @(negedge clk);
    while ((idx < words.size() || exp_q.size() > 0) && budget < 3000) begin
      in_valid = (idx < words.size());
      if (in_valid) begin in_data = words[idx]; in_last = lasts[idx]; end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (lat_pending && out_valid) begin
        check("stream_latency", 32'(cyc - acc_cyc), 32'(NS));
        lat_pending = 0;
      end
      check("no_overlap", 32'(in_ready & out_valid), 32'd0);
      if (in_valid && in_ready) begin
        if (gap > 0 && acc_cyc >= 0) check("accept_gap", 32'(cyc - acc_cyc), 32'(gap));
        exp_q.push_back(ref_xor(words[idx]));
        exp_l.push_back(lasts[idx]);
        acc_cyc = cyc; lat_pending = 1; idx++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("stream_data", 32'(out_data), 32'(exp_q[0]));
          check("stream_last", 32'(out_last), 32'(exp_l[0]));
          $display("stream out %h last=%0d (expected %h)", out_data, out_last, exp_q[0]);
          void'(exp_q.pop_front());
          void'(exp_l.pop_front());
        end
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      @(negedge clk);
      cyc++; budget++;
    end
    check("stream_done", 32'(budget < 3000), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    words.delete(); lasts.delete();
  endtask

  initial begin
    int n;
    int lat;
    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst2_in_ready", 32'(in_ready2), 32'd1);
    rst = 1'b0;

    one_word(24'hF03C5A, 1'b1, 0);
    one_word(24'hF03C5A, 1'b1, 5);

    words.push_back(24'h442211); lasts.push_back(1'b0);
    words.push_back(24'h00AAAA); lasts.push_back(1'b1);
    stream(1'b0, NS + 1);

    // Reset while the word is in its first XOR cycle.
    @(negedge clk);
    in_data = 24'h123456; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_out", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    $display("mid-operation reset: out_valid=%0d out_data=%h", out_valid, out_data);

    for (int i = 0; i < 30; i++) begin
      words.push_back((NS*W)'($urandom));
      lasts.push_back(1'($urandom_range(0, 1)));
    end
    stream(1'b1, 0);

    for (int i = 0; i < 4; i++) one_word((NS*W)'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Two-share instance.
    @(negedge clk);
    in_data2 = 16'hC33C; in_valid2 = 1'b1;
    n = 0;
    while (!in_ready2 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid2 && lat < 20) begin @(negedge clk); lat++; end
    check("ns2_latency", 32'(lat), 32'd2);
    check("ns2_data", 32'(out_data2), 32'hFF);
    @(negedge clk);
    check("ns2_idle", 32'(in_ready2), 32'd1);
    $display("ns2 word c33c -> %h latency %0d", out_data2, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
